// File: rtl/instruction_fetch_if.sv
// Single-port memory read channel between the fetch unit and memory.
// The requester holds req and addr steady until it sees ack; ack may come
// in the same cycle as req.
interface instruction_fetch_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch/decode front end: T0 (AR<-PC), T1 (IR<-M[AR], PC+1), T2 (decode),
// optional T3 (indirect AR<-M[AR]), then READY until the control unit
// reports execute done.
module instruction_fetch #(
  parameter int unsigned   AW     = 12,
  parameter int unsigned   DW     = 16,
  parameter logic [AW-1:0] PC_RST = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt,
  instruction_fetch_if.master mem,
  input  logic                exec_done,
  input  logic                pc_load,
  input  logic [AW-1:0]       pc_load_val,
  output logic [DW-1:0]       ir,
  output logic [2:0]          opcode,
  output logic                ind,
  output logic [AW-1:0]       ar,
  output logic [AW-1:0]       pc,
  output logic                instr_valid,
  output logic                busy
);

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StReady
  } state_e;

  state_e state_q, state_d;

  assign opcode = ir[DW-2:DW-4];

  // AR only changes outside T1/T3, so the address is stable while requesting.
  assign mem.mem_addr = ar;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    if (mem.mem_ack) state_d = StT2;
      // Opcode 111 is register/IO reference: the I bit is not an indirect flag.
      StT2:    state_d = (ir[DW-1] && (opcode != 3'b111)) ? StT3 : StReady;
      StT3:    if (mem.mem_ack) state_d = StReady;
      StReady: if (exec_done) state_d = halt ? StIdle : StT0;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    mem.mem_req = (state_q == StT1) || (state_q == StT3);
    instr_valid = (state_q == StReady);
    busy        = (state_q != StIdle);
  end

  // Datapath registers: PC, AR, IR and the latched I bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= PC_RST;
      ar  <= '0;
      ir  <= '0;
      ind <= 1'b0;
    end else begin
      case (state_q)
        StT0: ar <= pc;
        StT1: begin
          if (mem.mem_ack) begin
            ir <= mem.mem_rdata;
            pc <= pc + AW'(1);
          end
        end
        StT2: begin
          ar  <= ir[AW-1:0];
          ind <= ir[DW-1];
        end
        StT3: if (mem.mem_ack) ar <= mem.mem_rdata[AW-1:0];
        StReady: if (pc_load) pc <= pc_load_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed fetch scenarios with literal
// expectations, then random stimulus against a procedural reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        exec_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [11:0] pc_load_val = '0;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic        ind;
  logic [11:0] ar;
  logic [11:0] pc;
  logic        instr_valid;
  logic        busy;

  instruction_fetch_if #(.AW(12), .DW(16)) mem_if ();

  instruction_fetch #(.AW(12), .DW(16), .PC_RST(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .mem         (mem_if),
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .ir          (ir),
    .opcode      (opcode),
    .ind         (ind),
    .ar          (ar),
    .pc          (pc),
    .instr_valid (instr_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [4096];
  int          wait_q[$];
  int          default_wait = 0;
  bit          rand_mode = 0;
  bit          ack_force = 0;
  bit          pending = 0;
  int          cnt = 0;

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_force) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'hFFFF;
        pending          = 0;
      end else if (!rst) begin
        pending        = 0;
        mem_if.mem_ack = 1'b0;
      end else if (mem_if.mem_req) begin
        if (!pending) begin
          pending = 1;
          if (wait_q.size() > 0) cnt = wait_q.pop_front();
          else if (rand_mode) cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
          else cnt = default_wait;
        end
        if (cnt == 0) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem[mem_if.mem_addr];
          pending          = 0;
        end else begin
          cnt--;
          mem_if.mem_ack   = 1'b0;
          mem_if.mem_rdata = 16'($urandom);
        end
      end else begin
        // Stray acks outside a request must be ignored by the DUT.
        pending          = 0;
        mem_if.mem_ack   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_if.mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- reference model ----------------
  // Written as a straight-line fetch procedure; every step() is one clock edge.
  logic [11:0] m_pc, m_ar;
  logic [15:0] m_ir;
  bit          m_ind, m_req, m_valid, m_busy;

  task automatic step(output bit ab);
    @(posedge clk or negedge rst);
    ab = !rst;
  endtask

  task automatic model_run();
    bit ab;
    forever begin
      m_busy = 0; m_valid = 0; m_req = 0;
      do begin step(ab); if (ab) return; end while (!start);
      m_busy = 1;
      forever begin
        step(ab); if (ab) return;
        m_ar = m_pc; m_req = 1;
        do begin step(ab); if (ab) return; end while (!mem_if.mem_ack);
        m_ir = mem_if.mem_rdata; m_pc = m_pc + 12'd1; m_req = 0;
        step(ab); if (ab) return;
        m_ar = m_ir[11:0]; m_ind = m_ir[15];
        if (m_ind && m_ir[14:12] != 3'd7) begin
          m_req = 1;
          do begin step(ab); if (ab) return; end while (!mem_if.mem_ack);
          m_ar = mem_if.mem_rdata[11:0]; m_req = 0;
        end
        m_valid = 1;
        do begin
          step(ab); if (ab) return;
          if (pc_load) m_pc = pc_load_val;
        end while (!exec_done);
        m_valid = 0;
        if (halt) break;
      end
    end
  endtask

  initial begin
    forever begin
      m_pc = 12'h000; m_ar = '0; m_ir = '0; m_ind = 0;
      m_req = 0; m_valid = 0; m_busy = 0;
      wait (rst === 1'b1);
      model_run();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("busy", busy, m_busy);
        check("instr_valid", instr_valid, m_valid);
        check("mem_req", mem_if.mem_req, m_req);
        if (m_req && mem_if.mem_req) check("mem_addr", mem_if.mem_addr, m_ar);
        check("pc", pc, m_pc);
        check("ar", ar, m_ar);
        check("ir", ir, m_ir);
        check("ind", ind, m_ind);
        check("opcode", opcode, m_ir[14:12]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [11:0] req_log[$];
  logic [15:0] first_ir;

  function automatic logic [31:0] logat(input int i);
    return (req_log.size() > i) ? {20'h0, req_log[i]} : 32'hDEAD_BEEF;
  endfunction

  // Launch via start or exec_done, then count edges after the launch edge
  // until instr_valid, logging the address of every request cycle.
  task automatic kick(input bit use_start, input bit pl, input logic [11:0] pv,
                      output int n);
    @(negedge clk);
    if (use_start) start = 1'b1;
    else begin
      exec_done   = 1'b1;
      pc_load     = pl;
      pc_load_val = pv;
    end
    req_log.delete();
    first_ir = 16'hxxxx;
    @(posedge clk);
    #1;
    start = 1'b0; exec_done = 1'b0; pc_load = 1'b0;
    n = 0;
    while (!instr_valid && n < 40) begin
      if (mem_if.mem_req) begin
        if (req_log.size() == 0) first_ir = ir;
        req_log.push_back(mem_if.mem_addr);
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 12'h000);
    check({tag, "_ir"}, ir, 16'h0000);
    check({tag, "_ar"}, ar, 12'h000);
    check({tag, "_ind"}, ind, 1'b0);
    check({tag, "_mem_req"}, mem_if.mem_req, 1'b0);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // Reset state, then a direct fetch.
    #22;
    check_reset_outputs("reset");
    mem[12'h000] = 16'h2005;
    @(negedge clk);
    rst = 1'b1;
    kick(1'b1, 1'b0, 12'h000, n);
    check("direct_latency", n, 3);
    check("direct_nreq", req_log.size(), 1);
    check("direct_addr", logat(0), 12'h000);
    check("direct_opcode", opcode, 3'b010);
    check("direct_ind", ind, 1'b0);
    check("direct_ar", ar, 12'h005);
    check("direct_pc", pc, 12'h001);
    check("model_ar_pin", m_ar, 12'h005);

    // Indirect fetch.
    mem[12'h000] = 16'hA010;
    mem[12'h010] = 16'h0123;
    kick(1'b0, 1'b1, 12'h000, n);
    check("indir_latency", n, 4);
    check("indir_nreq", req_log.size(), 2);
    check("indir_addr0", logat(0), 12'h000);
    check("indir_addr1", logat(1), 12'h010);
    check("indir_ar", ar, 12'h123);
    check("indir_ind", ind, 1'b1);
    check("indir_opcode", opcode, 3'b010);
    check("model_ind_pin", m_ind, 1'b1);

    // Register reference: I bit set but opcode 111, no indirect read.
    mem[12'h000] = 16'hF800;
    kick(1'b0, 1'b1, 12'h000, n);
    check("regref_latency", n, 3);
    check("regref_nreq", req_log.size(), 1);
    check("regref_ind", ind, 1'b1);
    check("regref_opcode", opcode, 3'b111);
    check("regref_ar", ar, 12'h800);

    // Three wait states in T1.
    default_wait = 3;
    mem[12'h000] = 16'h1234;
    kick(1'b0, 1'b1, 12'h000, n);
    default_wait = 0;
    check("wait_latency", n, 6);
    check("wait_nreq", req_log.size(), 4);
    check("wait_addr3", logat(3), 12'h000);
    check("wait_ir_held", first_ir, 16'hF800);
    check("wait_ir", ir, 16'h1234);

    // PC wrap at 0xFFF.
    mem[12'hFFF] = 16'h3007;
    kick(1'b0, 1'b1, 12'hFFF, n);
    check("wrap_addr", logat(0), 12'hFFF);
    check("wrap_pc", pc, 12'h000);
    check("wrap_ar", ar, 12'h007);
    check("model_pc_pin", m_pc, 12'h000);

    // Branch with exec_done in the same cycle.
    mem[12'h040] = 16'h4001;
    kick(1'b0, 1'b1, 12'h040, n);
    check("branch_addr", logat(0), 12'h040);
    check("branch_pc", pc, 12'h041);
    check("branch_latency", n, 3);

    // Halt back to IDLE.
    @(negedge clk);
    exec_done = 1'b1;
    halt      = 1'b1;
    @(posedge clk);
    #1;
    exec_done = 1'b0;
    halt      = 1'b0;
    check("halt_busy", busy, 1'b0);
    check("halt_valid", instr_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("halt_stays_idle", busy, 1'b0);

    // Async reset while waiting in T3, followed by stray acks.
    mem[12'h041] = 16'hA020;
    mem[12'h020] = 16'h0555;
    wait_q.push_back(0);
    wait_q.push_back(6);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(mem_if.mem_req && mem_if.mem_addr == 12'h020) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t3_reached", mem_if.mem_req && mem_if.mem_addr == 12'h020, 1'b1);
    #2;
    rst = 1'b0;
    ack_force = 1'b1;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0;
    check("late_ack_ir", ir, 16'h0000);
    check("late_ack_ar", ar, 12'h000);
    check("late_ack_pc", pc, 12'h000);
    check("late_ack_busy", busy, 1'b0);
    wait_q.delete();

    // Random phase.
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rand_mode = 1;
    repeat (4000) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      start       = ($urandom_range(0, 7) == 0);
      exec_done   = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 7) == 0);
      pc_load     = ($urandom_range(0, 3) == 0);
      pc_load_val = 12'($urandom);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0; exec_done = 1'b0; halt = 1'b0; pc_load = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch/decode front end of the basic-computer datapath. Sits directly upstream of the control unit.
- Runs the T0–T3 fetch cycle: AR<-PC, IR<-M[AR] with PC+1, decode, optional indirect address read.
- Presents the opcode, I bit and effective AR to the control unit, then holds them until the control unit reports execute done.
- Talks to memory over a single req/ack read port.

Parameters:
- AW, 12, address width of PC, AR and memory address.
- DW, 16, instruction/memory data width; IR[DW-1] is the I bit, IR[DW-2:DW-4] is the opcode.
- PC_RST, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- halt  in  1  return to IDLE instead of refetching when exec_done is seen.
- mem_req  out  1  memory read request.
- mem_addr  out  AW  read address; equals AR while mem_req=1.
- mem_rdata  in  DW  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  read complete; may be asserted in the same cycle as mem_req.
- exec_done  in  1  control unit finished the current instruction.
- pc_load  in  1  execute stage overrides the next PC (branch).
- pc_load_val  in  AW  new PC value.
- ir  out  DW  instruction register.
- opcode  out  3  IR[DW-2:DW-4]; drives the 3-to-8 opcode decoder.
- ind  out  1  latched I bit (IR[DW-1]).
- ar  out  AW  address register (effective address once instr_valid=1).
- pc  out  AW  program counter.
- instr_valid  out  1  ir/opcode/ind/ar are stable and valid for execute.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pc=PC_RST; ir=0; ar=0; ind=0; mem_req=0; instr_valid=0; busy=0. Reset mid-transaction abandons the read; any later mem_ack is ignored.
- States:
  - IDLE: start=1 -> T0.
  - T0: ar<=pc -> T1.
  - T1 (fetch):
    - mem_req=1, mem_addr=ar.
    - Stay in T1 while mem_ack=0.
    - On an edge with mem_ack=1: ir<=mem_rdata; pc<=pc+1 (mod 2^AW, so 4095 -> 0 with AW=12) -> T2.
  - T2 (decode): ar<=ir[AW-1:0]; ind<=ir[DW-1].
    - ind=1 and opcode!=3'b111 -> T3.
    - Otherwise -> READY.
  - T3 (indirect):
    - mem_req=1, mem_addr=ar.
    - Wait for mem_ack; on mem_ack: ar<=mem_rdata[AW-1:0] -> READY.
  - READY: instr_valid=1; ir, opcode, ind and ar are held.
    - exec_done=1 with halt=0 -> T0.
    - exec_done=1 with halt=1 -> IDLE.
    - exec_done=0 -> stay in READY.
- opcode is combinational from ir. ind is taken from ir in T2, not from mem_rdata.
- mem_req is registered-state decoded: high exactly in T1 and T3, and held until the ack edge. mem_addr must not change while mem_req=1. mem_ack outside T1/T3 is ignored.
- pc_load is honoured only in READY and sets pc<=pc_load_val.
  - pc_load together with exec_done in the same cycle: the load takes effect, and the next T0 uses pc_load_val.
  - pc_load in any other state is ignored.
- Latency with a zero-wait memory (ack in the same cycle as req):
  - start sampled at edge 0 -> instr_valid=1 after edge 3 for direct instructions, after edge 4 for indirect.
  - Each wait cycle on mem_ack adds one cycle.
  - exec_done -> next instr_valid is also 3 edges later (direct).
- start while not in IDLE: ignored. halt outside READY: ignored.

Test Plan:
- Reset then direct fetch: pc=0, M[0]=16'h2005, zero-wait ack, pulse start.
  - Expect: mem_addr=0 in T1; instr_valid after 3 edges; opcode=3'b010, ind=0, ar=12'h005, pc=1.
- Indirect fetch: M[0]=16'hA010, M[0x010]=16'h0123.
  - Expect: second request at addr 0x010; ar=12'h123, ind=1, opcode=3'b010; instr_valid after 4 edges.
- Register-reference (no indirect) check: M[0]=16'hF800.
  - Expect: no T3 request; ind=1, opcode=3'b111; instr_valid after 3 edges.
- Wait states: mem_ack delayed 3 cycles in T1.
  - Expect: mem_req held high and mem_addr stable for 4 cycles; ir captured only on the ack edge; instr_valid after 6 edges.
- Branch and wrap:
  - pc=12'hFFF fetch -> pc wraps to 12'h000.
  - In READY, pc_load=1 with pc_load_val=12'h040 and exec_done=1 in the same cycle -> next T1 mem_addr=12'h040.
  - halt=1 with exec_done -> IDLE, busy=0.
- Async reset mid-T3: drive rst=0 between clock edges.
  - Expect: outputs reset immediately; a late mem_ack causes no capture.
